// File: rtl/restart_scheduler.sv
// restart_scheduler: central arbiter for pipeline restart requests.
// Picks the oldest requester (M > X > D), redirects IF over a valid/ready
// handshake, and holds per-stage flushes until the pipeline has drained.
module restart_scheduler #(
   parameter int FLUSH_CYCLES = 2,
   parameter int PERF_W       = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              d_restart,
   input  logic [31:0]       d_restart_pc,
   input  logic              x_restart,
   input  logic [31:0]       x_restart_pc,
   input  logic              m_restart,
   input  logic [31:0]       m_restart_pc,
   input  logic              f_ready,
   output logic              restart_valid,
   output logic [31:0]       restart_pc,
   output logic              flush_D,
   output logic              flush_X,
   output logic              flush_M,
   output logic              busy,
   output logic [PERF_W-1:0] perf_restarts,
   output logic [PERF_W-1:0] perf_dropped,
   output logic [PERF_W-1:0] perf_stall
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [1:0]         rank, rank_n;
   logic [31:0]        pc_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic [1:0]         win_rank;
   logic [31:0]        win_pc;
   logic [1:0]         req_cnt;
   logic [1:0]         drop_inc;
   logic               restart_inc;
   logic               stall_inc;
   logic               busy_n;

   // Same-cycle winner: the oldest stage (highest rank) wins; also count requesters.
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise
      // a path that skips the assignment infers a latch.
      win_rank = 2'd0;
      win_pc   = 32'd0;
      if (m_restart) begin
         win_rank = 2'd3;
         win_pc   = m_restart_pc;
      end else if (x_restart) begin
         win_rank = 2'd2;
         win_pc   = x_restart_pc;
      end else if (d_restart) begin
         win_rank = 2'd1;
         win_pc   = d_restart_pc;
      end
      req_cnt = {1'b0, d_restart} + {1'b0, x_restart} + {1'b0, m_restart};
   end

   // Next-state, latched request and counter increments.
   always_comb begin
      state_n     = state;
      rank_n      = rank;
      pc_n        = restart_pc;
      cnt_n       = cnt;
      drop_inc    = 2'd0;
      restart_inc = 1'b0;
      stall_inc   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_cnt != 2'd0) begin
               state_n  = REDIRECT;
               rank_n   = win_rank;
               pc_n     = win_pc;
               drop_inc = req_cnt - 2'd1;
            end
         end
         REDIRECT: begin
            stall_inc = ~f_ready;
            // Losers are dropped; on preemption the unaccepted redirect
            // replaces the winner in the drop count, so it is req_cnt either way.
            drop_inc  = req_cnt;
            if (win_rank > rank) begin
               rank_n = win_rank;
               pc_n   = win_pc;
            end else if (f_ready) begin
               state_n     = DRAIN;
               cnt_n       = CNT_W'(FLUSH_CYCLES - 1);
               restart_inc = 1'b1;
            end
         end
         DRAIN: begin
            // An older request preempts; on the last drain cycle any request
            // is served directly so no idle cycle is lost.
            if ((win_rank > rank) || ((cnt == '0) && (req_cnt != 2'd0))) begin
               state_n  = REDIRECT;
               rank_n   = win_rank;
               pc_n     = win_pc;
               drop_inc = req_cnt - 2'd1;
            end else begin
               drop_inc = req_cnt;
               if (cnt == '0) state_n = IDLE;
               else           cnt_n   = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, latched redirect and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         rank          <= 2'd0;
         cnt           <= '0;
         restart_pc    <= 32'd0;
         restart_valid <= 1'b0;
         flush_D       <= 1'b0;
         flush_X       <= 1'b0;
         flush_M       <= 1'b0;
         busy          <= 1'b0;
         perf_restarts <= '0;
         perf_dropped  <= '0;
         perf_stall    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state         <= state_n;
         rank          <= rank_n;
         cnt           <= cnt_n;
         restart_pc    <= pc_n;
         restart_valid <= (state_n == REDIRECT);
         flush_D       <= busy_n && (rank_n >= 2'd1);
         flush_X       <= busy_n && (rank_n >= 2'd2);
         flush_M       <= busy_n && (rank_n == 2'd3);
         busy          <= busy_n;
         perf_restarts <= perf_restarts + PERF_W'(restart_inc);
         perf_dropped  <= perf_dropped + PERF_W'(drop_inc);
         perf_stall    <= perf_stall + PERF_W'(stall_inc);
      end
   end

endmodule

// File: tb/tb_restart_scheduler.sv
// tb_restart_scheduler: directed scenarios plus randomized traffic checked
// against a behavioural model of the restart rules.
module tb_restart_scheduler;

   localparam int FLUSH_CYCLES = 2;
   localparam int PERF_W       = 32;

   logic              clock;
   logic              reset_n;
   logic              d_restart, x_restart, m_restart;
   logic [31:0]       d_restart_pc, x_restart_pc, m_restart_pc;
   logic              f_ready;
   logic              restart_valid;
   logic [31:0]       restart_pc;
   logic              flush_D, flush_X, flush_M;
   logic              busy;
   logic [PERF_W-1:0] perf_restarts, perf_dropped, perf_stall;

   int checks   = 0;
   int failures = 0;

   // Model: a pending redirect, a count of drain cycles left, and counters.
   bit          md_pending;
   int          md_left;
   int          md_rank;
   logic [31:0] md_pc;
   logic [31:0] md_restarts, md_dropped, md_stall;

   restart_scheduler #(.FLUSH_CYCLES(FLUSH_CYCLES), .PERF_W(PERF_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .d_restart    (d_restart),
      .d_restart_pc (d_restart_pc),
      .x_restart    (x_restart),
      .x_restart_pc (x_restart_pc),
      .m_restart    (m_restart),
      .m_restart_pc (m_restart_pc),
      .f_ready      (f_ready),
      .restart_valid(restart_valid),
      .restart_pc   (restart_pc),
      .flush_D      (flush_D),
      .flush_X      (flush_X),
      .flush_M      (flush_M),
      .busy         (busy),
      .perf_restarts(perf_restarts),
      .perf_dropped (perf_dropped),
      .perf_stall   (perf_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      md_pending  = 1'b0;
      md_left     = 0;
      md_rank     = 0;
      md_pc       = 32'd0;
      md_restarts = 32'd0;
      md_dropped  = 32'd0;
      md_stall    = 32'd0;
   endtask

   // Apply the restart rules for one clock edge using the current inputs.
   task automatic model_step();
      int          reqs;
      int          wr;
      logic [31:0] wp;
      reqs = int'(d_restart) + int'(x_restart) + int'(m_restart);
      wr   = m_restart ? 3 : x_restart ? 2 : d_restart ? 1 : 0;
      wp   = m_restart ? m_restart_pc : x_restart ? x_restart_pc : d_restart ? d_restart_pc : 32'd0;
      if (!md_pending && md_left == 0) begin
         if (reqs > 0) begin
            md_pending = 1'b1; md_rank = wr; md_pc = wp;
            md_dropped += 32'(reqs - 1);
         end
      end else if (md_pending) begin
         if (!f_ready) md_stall += 32'd1;
         md_dropped += 32'(reqs);
         if (wr > md_rank) begin
            md_rank = wr; md_pc = wp;
         end else if (f_ready) begin
            md_pending = 1'b0;
            md_left    = FLUSH_CYCLES;
            md_restarts += 32'd1;
         end
      end else begin
         if (wr > md_rank || (md_left == 1 && reqs > 0)) begin
            md_left = 0; md_pending = 1'b1; md_rank = wr; md_pc = wp;
            md_dropped += 32'(reqs - 1);
         end else begin
            md_dropped += 32'(reqs);
            md_left--;
         end
      end
   endtask

   task automatic set_req(input bit d, input logic [31:0] dpc, input bit x, input logic [31:0] xpc,
                          input bit m, input logic [31:0] mpc, input bit fr);
      d_restart = d; d_restart_pc = dpc;
      x_restart = x; x_restart_pc = xpc;
      m_restart = m; m_restart_pc = mpc;
      f_ready   = fr;
   endtask

   task automatic clear_req();
      d_restart = 1'b0; x_restart = 1'b0; m_restart = 1'b0;
   endtask

   // One clock: the model consumes the inputs seen at the edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      set_req(0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({restart_valid, restart_pc, flush_D, flush_X, flush_M, busy,
           perf_restarts, perf_dropped, perf_stall} !== '0) begin
         failures++;
         $display("FAIL reset_state: valid=%b pc=%h flush=%b%b%b busy=%b perf=%0d/%0d/%0d, required all 0",
                  restart_valid, restart_pc, flush_D, flush_X, flush_M, busy,
                  perf_restarts, perf_dropped, perf_stall);
      end
      set_req(1, 32'h100, 0, 0, 0, 0, 0);
      tick();
      clear_req();
      tick();
      tick();
      tick();
      checks++;
      if (restart_valid !== 1'b1 || restart_pc !== 32'h100 || perf_stall !== 32'd3) begin
         failures++;
         $display("FAIL reset_pre_state: valid=%b pc=%h stall=%0d, required 1 00000100 3",
                  restart_valid, restart_pc, perf_stall);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({restart_valid, restart_pc, flush_D, flush_X, flush_M, busy,
           perf_restarts, perf_dropped, perf_stall} !== '0) begin
         failures++;
         $display("FAIL reset_async: valid=%b pc=%h flush=%b%b%b busy=%b stall=%0d, required all 0",
                  restart_valid, restart_pc, flush_D, flush_X, flush_M, busy, perf_stall);
      end
      #1 reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single_x();
      do_reset();
      set_req(0, 0, 1, 32'h8000_0040, 0, 0, 1);
      tick();
      clear_req();
      checks++;
      if ({restart_valid, flush_D, flush_X, flush_M} !== 4'b1110 || restart_pc !== 32'h8000_0040) begin
         failures++;
         $display("FAIL single_x_redirect: valid/fD/fX/fM=%b%b%b%b pc=%h, required 1110 80000040",
                  restart_valid, flush_D, flush_X, flush_M, restart_pc);
      end
      tick();
      checks++;
      if ({restart_valid, flush_D, flush_X, flush_M, busy} !== 5'b01101 || perf_restarts !== 32'd1) begin
         failures++;
         $display("FAIL single_x_drain1: valid/fD/fX/fM/busy=%b%b%b%b%b restarts=%0d, required 01101 1",
                  restart_valid, flush_D, flush_X, flush_M, busy, perf_restarts);
      end
      tick();
      checks++;
      if ({restart_valid, flush_D, flush_X, flush_M, busy} !== 5'b01101) begin
         failures++;
         $display("FAIL single_x_drain2: valid/fD/fX/fM/busy=%b%b%b%b%b, required 01101",
                  restart_valid, flush_D, flush_X, flush_M, busy);
      end
      tick();
      checks++;
      if ({restart_valid, flush_D, flush_X, flush_M, busy} !== 5'b00000 || perf_restarts !== 32'd1) begin
         failures++;
         $display("FAIL single_x_idle: valid/fD/fX/fM/busy=%b%b%b%b%b restarts=%0d, required 00000 1",
                  restart_valid, flush_D, flush_X, flush_M, busy, perf_restarts);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_req(1, 32'h10, 1, 32'h20, 1, 32'h30, 0);
      tick();
      clear_req();
      checks++;
      if (restart_pc !== 32'h30 || {flush_D, flush_X, flush_M} !== 3'b111 || perf_dropped !== 32'd2) begin
         failures++;
         $display("FAIL simultaneous: pc=%h flush=%b%b%b dropped=%0d, required 00000030 111 2",
                  restart_pc, flush_D, flush_X, flush_M, perf_dropped);
      end
   endtask

   task automatic test_preemption();
      do_reset();
      set_req(0, 0, 1, 32'h200, 0, 0, 0);
      tick();
      clear_req();
      tick();
      set_req(0, 0, 0, 0, 1, 32'h300, 0);
      tick();
      clear_req();
      checks++;
      if (restart_valid !== 1'b1 || restart_pc !== 32'h300 || flush_M !== 1'b1 ||
          perf_dropped !== 32'd1 || perf_stall !== 32'd2) begin
         failures++;
         $display("FAIL preemption: valid=%b pc=%h fM=%b dropped=%0d stall=%0d, required 1 00000300 1 1 2",
                  restart_valid, restart_pc, flush_M, perf_dropped, perf_stall);
      end
      f_ready = 1'b1;
      tick();
      checks++;
      if (restart_valid !== 1'b0 || perf_restarts !== 32'd1 || perf_stall !== 32'd2) begin
         failures++;
         $display("FAIL preemption_accept: valid=%b restarts=%0d stall=%0d, required 0 1 2",
                  restart_valid, perf_restarts, perf_stall);
      end
   endtask

   task automatic test_lower_drop();
      do_reset();
      set_req(0, 0, 0, 0, 1, 32'h500, 1);
      tick();
      clear_req();
      tick();
      set_req(1, 32'h44, 0, 0, 0, 0, 1);
      tick();
      clear_req();
      checks++;
      if (restart_valid !== 1'b0 || busy !== 1'b1 || flush_M !== 1'b1 || perf_dropped !== 32'd1) begin
         failures++;
         $display("FAIL lower_drop: valid=%b busy=%b fM=%b dropped=%0d, required 0 1 1 1",
                  restart_valid, busy, flush_M, perf_dropped);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || restart_valid !== 1'b0 || restart_pc !== 32'h500) begin
         failures++;
         $display("FAIL lower_drop_idle: busy=%b valid=%b pc=%h, required 0 0 00000500",
                  busy, restart_valid, restart_pc);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_req(0, 0, 1, 32'h600, 0, 0, 1);
      tick();
      clear_req();
      tick();
      tick();
      set_req(1, 32'h700, 0, 0, 0, 0, 1);
      tick();
      clear_req();
      checks++;
      if (restart_valid !== 1'b1 || restart_pc !== 32'h700 || busy !== 1'b1 ||
          {flush_D, flush_X, flush_M} !== 3'b100 || perf_dropped !== 32'd0) begin
         failures++;
         $display("FAIL back_to_back: valid=%b pc=%h busy=%b flush=%b%b%b dropped=%0d, required 1 00000700 1 100 0",
                  restart_valid, restart_pc, busy, flush_D, flush_X, flush_M, perf_dropped);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         set_req($urandom_range(0, 4) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 1) == 1);
         tick();
         exp_pc = md_pc;
         checks++;
         if (restart_valid !== md_pending || restart_pc !== exp_pc ||
             busy !== (md_pending || md_left > 0) ||
             flush_D !== (busy && md_rank >= 1) || flush_X !== (busy && md_rank >= 2) ||
             flush_M !== (busy && md_rank == 3) ||
             perf_restarts !== md_restarts || perf_dropped !== md_dropped || perf_stall !== md_stall) begin
            failures++;
            $display("FAIL random[%0d]: valid=%b pc=%h busy=%b flush=%b%b%b perf=%0d/%0d/%0d, required valid=%b pc=%h busy=%b rank=%0d perf=%0d/%0d/%0d",
                     i, restart_valid, restart_pc, busy, flush_D, flush_X, flush_M,
                     perf_restarts, perf_dropped, perf_stall,
                     md_pending, exp_pc, (md_pending || md_left > 0), md_rank,
                     md_restarts, md_dropped, md_stall);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #3;
      test_reset();
      test_single_x();
      test_simultaneous();
      test_preemption();
      test_lower_drop();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
